matrix_multiply_top: RTL and testbench
======================================

// Module: matrix_multiply_top
// PURPOSE
//  Host-loaded matrix multiplier: Z = X * Y, where X is X_ROWS x X_COLS_Y_ROWS and Y is X_COLS_Y_ROWS x Y_COLS.
//  Three internal RAMs (X, Y, Z) are accessed through one shared address/data port; a start pulse launches the computation.
//  Sits behind a register/bus bridge in the DFR datapath; the host polls or edge-waits on busy.
// PARAMETERS
//  ADDR_WIDTH     4   host RAM address width; each RAM depth must be <= 2**ADDR_WIDTH
//  DATA_WIDTH     32  element width (unsigned) for X, Y, Z
//  X_ROWS         2   rows of X and of Z
//  Y_COLS         2   columns of Y and of Z
//  X_COLS_Y_ROWS  2   inner dimension (X columns = Y rows)
// PORTS
//  clk           in   1           single clock, rising edge
//  rst           in   1           asynchronous, active-low reset
//  start         in   1           1-cycle pulse; starts a multiply when idle
//  ram_addr      in   ADDR_WIDTH  host element address, row-major
//  ram_wen       in   1           host write enable
//  ram_sel       in   2           0=X, 1=Y, 2=Z (read-only), 3=unused
//  ram_data_in   in   DATA_WIDTH  host write data
//  busy          out  1           high while computing
//  ram_data_out  out  DATA_WIDTH  combinational read of RAM[ram_sel][ram_addr]
// BEHAVIOUR
//  - Storage, row-major: X[i][k] @ i*X_COLS_Y_ROWS+k; Y[k][j] @ k*Y_COLS+j; Z[i][j] @ i*Y_COLS+j.
//  - Reset (rst=0): busy=0, FSM=IDLE, accumulator=0, all X/Y/Z entries=0; ram_data_out then reads 0.
//  - Host write: on clk edge when ram_wen=1 and busy=0, write ram_data_in to X (sel 0) or Y (sel 1).
//  - Host writes are ignored for sel 2, sel 3, out-of-range addresses, and whenever busy=1.
//  - Host read: asynchronous and valid in any state.
//  - Host reads return 0 for sel 3 and for out-of-range addresses.
//  - FSM states: IDLE -> MAC -> WRITE -> (MAC for next element | IDLE).
//  - IDLE: when start=1, the next edge clears acc, sets i=j=k=0 and busy=1, and enters MAC.
//  - MAC: acc <= acc + X[i][k]*Y[k][j], keeping the low DATA_WIDTH bits (wraps). k increments each cycle.
//  - MAC exit: after the k=X_COLS_Y_ROWS-1 cycle, go to WRITE.
//  - WRITE: Z[i][j] <= acc; acc <= 0; k <= 0; advance j, and on wrap advance i.
//  - WRITE exit: after the last element (i=X_ROWS-1, j=Y_COLS-1), busy <= 0 and FSM returns to IDLE.
//  - Latency: busy stays high exactly X_ROWS*Y_COLS*(X_COLS_Y_ROWS+1) cycles (12 at the defaults).
//  - Z is fully updated in the same edge that busy falls.
//  - start while busy is ignored; there is no restart and no queueing.
//  - start and ram_wen in the same IDLE cycle: the write lands first, and the computation sees the new value.
//  - Reset mid-operation: the computation aborts immediately, all RAMs clear, busy=0.
//  - Z is only modified by WRITE; Z holds its last results until the next run or a reset.
// CONFIGURATION
//  MM_SATURATE_EN defined:
//   - the MAC product and the accumulation saturate at 2**DATA_WIDTH-1 (unsigned clamp, no wrap);
//   - once saturated, acc holds its maximum until the element is written.
//  MM_SATURATE_EN undefined: arithmetic is modulo 2**DATA_WIDTH. This is the default.
//  Cycle timing is identical in both builds.
// TESTING
//  1. Reset, then read every address on sel 0/1/2 -> all 0, busy=0.
//  2. Basic multiply:
//     - Load X={1,2,3,4} @0..3 and Y={5,6,7,8} @0..3, then pulse start.
//     - busy is high 12 cycles, then Z@0..3 = {19,22,43,50}.
//  3. Repeated address writes:
//     - Write X@0=1 twice, X@1=2 twice, Y@0=1 twice, Y@1=2 twice; all other entries stay 0.
//     - After start, Z@0..3 = {1,2,0,0}.
//  4. Writes while busy are ignored:
//     - During busy, write X@0=99 and pulse start again. Both are ignored.
//     - Results match scenario 2; X@0 still reads 1.
//  5. Wrap vs saturate:
//     - Set X@0=X@1=0xFFFFFFFF and Y@0=Y@2=2.
//     - Z@0 = 0xFFFFFFFC without the macro; Z@0 = 0xFFFFFFFF with MM_SATURATE_EN.
//  6. Reset mid-run: assert rst 5 cycles after start -> busy=0 at once, Z@0..3 read 0, and a new run completes normally.

Source files
------------

// File: rtl/matrix_multiply_top.sv
// Host-loaded X*Y matrix multiplier with X/Y/Z RAMs behind a shared port.
// Optional MM_SATURATE_EN: unsigned clamping MAC instead of modulo wrap.
module matrix_multiply_top #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int X_ROWS        = 2,
  parameter int Y_COLS        = 2,
  parameter int X_COLS_Y_ROWS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic                  ram_wen,
  input  logic [1:0]            ram_sel,
  input  logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] ram_data_out
);

  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int KC = X_COLS_Y_ROWS;
  localparam int XD = X_ROWS * KC;
  localparam int YD = KC * Y_COLS;
  localparam int ZD = X_ROWS * Y_COLS;
  localparam int IW = (X_ROWS > 1) ? $clog2(X_ROWS) : 1;
  localparam int JW = (Y_COLS > 1) ? $clog2(Y_COLS) : 1;
  localparam int KW = (KC > 1) ? $clog2(KC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_WRITE
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0] xm [XD];
  logic [DW-1:0] ym [YD];
  logic [DW-1:0] zm [ZD];

  logic [IW-1:0] i_q;
  logic [JW-1:0] j_q;
  logic [KW-1:0] k_q;
  logic [DW-1:0] acc_q;
  logic [DW-1:0] acc_nxt;
  logic [DW-1:0] x_op;
  logic [DW-1:0] y_op;
  logic [AW-1:0] x_idx;
  logic [AW-1:0] y_idx;
  logic [AW-1:0] z_idx;
  logic          i_last;
  logic          j_last;
  logic          k_last;
  logic          sel_x;
  logic          sel_y;
  logic          sel_z;

  assign busy   = (state_q != S_IDLE);
  assign i_last = (i_q == IW'(X_ROWS - 1));
  assign j_last = (j_q == JW'(Y_COLS - 1));
  assign k_last = (k_q == KW'(KC - 1));

  assign x_idx = AW'(i_q) * AW'(KC) + AW'(k_q);
  assign y_idx = AW'(k_q) * AW'(Y_COLS) + AW'(j_q);
  assign z_idx = AW'(i_q) * AW'(Y_COLS) + AW'(j_q);

  assign sel_x = (ram_sel == 2'd0);
  assign sel_y = (ram_sel == 2'd1);
  assign sel_z = (ram_sel == 2'd2);

  always_comb begin
    x_op = '0;
    y_op = '0;
    for (int n = 0; n < XD; n++)
      if (x_idx == AW'(n)) x_op = xm[n];
    for (int n = 0; n < YD; n++)
      if (y_idx == AW'(n)) y_op = ym[n];
  end

`ifdef MM_SATURATE_EN
  logic [2*DW-1:0] prod;
  logic [DW-1:0]   prod_sat;
  logic [DW:0]     sum;

  // Clamp the product first, then the carry of the running sum.
  always_comb begin
    prod     = {{DW{1'b0}}, x_op} * {{DW{1'b0}}, y_op};
    prod_sat = (|prod[2*DW-1:DW]) ? '1 : prod[DW-1:0];
    sum      = {1'b0, acc_q} + {1'b0, prod_sat};
    acc_nxt  = sum[DW] ? '1 : sum[DW-1:0];
  end
`else
  always_comb begin
    acc_nxt = acc_q + x_op * y_op;
  end
`endif

  always_comb begin
    ram_data_out = '0;
    unique case (1'b1)
      sel_x:
        for (int n = 0; n < XD; n++)
          if (ram_addr == AW'(n)) ram_data_out = xm[n];
      sel_y:
        for (int n = 0; n < YD; n++)
          if (ram_addr == AW'(n)) ram_data_out = ym[n];
      sel_z:
        for (int n = 0; n < ZD; n++)
          if (ram_addr == AW'(n)) ram_data_out = zm[n];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < XD; n++) xm[n] <= '0;
      for (int n = 0; n < YD; n++) ym[n] <= '0;
    end else if (ram_wen && !busy) begin
      for (int n = 0; n < XD; n++)
        if (sel_x && ram_addr == AW'(n)) xm[n] <= ram_data_in;
      for (int n = 0; n < YD; n++)
        if (sel_y && ram_addr == AW'(n)) ym[n] <= ram_data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_MAC;
      S_MAC:   if (k_last) state_d = S_WRITE;
      S_WRITE: state_d = (i_last && j_last) ? S_IDLE : S_MAC;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      i_q   <= '0;
      j_q   <= '0;
      k_q   <= '0;
      for (int n = 0; n < ZD; n++) zm[n] <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_q <= '0;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
          end
        end
        S_MAC: begin
          acc_q <= acc_nxt;
          if (!k_last) k_q <= k_q + KW'(1);
        end
        S_WRITE: begin
          for (int n = 0; n < ZD; n++)
            if (z_idx == AW'(n)) zm[n] <= acc_q;
          acc_q <= '0;
          k_q   <= '0;
          if (j_last) begin
            j_q <= '0;
            i_q <= i_last ? '0 : i_q + IW'(1);
          end else begin
            j_q <= j_q + JW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_multiply_top.sv
// Scoreboard bench for matrix_multiply_top: model pushes expected Z on
// start, results are popped and compared when busy falls.
module tb_matrix_multiply_top;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int XR = 2;
  localparam int YC = 2;
  localparam int KC = 2;
  localparam int LAT = XR * YC * (KC + 1);
  localparam logic [DW-1:0] MAXV = '1;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] ram_addr;
  logic          ram_wen;
  logic [1:0]    ram_sel;
  logic [DW-1:0] ram_data_in;
  logic          busy;
  logic [DW-1:0] ram_data_out;

  int checks;
  int errors;
  logic [DW-1:0] mx [XR*KC];
  logic [DW-1:0] my [KC*YC];
  logic [DW-1:0] zq [$];
  logic [DW-1:0] d;

  matrix_multiply_top #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .X_ROWS(XR),
    .Y_COLS(YC),
    .X_COLS_Y_ROWS(KC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .ram_addr(ram_addr),
    .ram_wen(ram_wen),
    .ram_sel(ram_sel),
    .ram_data_in(ram_data_in),
    .busy(busy),
    .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int n = 0; n < XR*KC; n++) mx[n] = '0;
    for (int n = 0; n < KC*YC; n++) my[n] = '0;
  endtask

  task automatic push_expected();
    logic [DW-1:0] a;
    logic [63:0]   p;
    logic [63:0]   s;
    for (int i = 0; i < XR; i++)
      for (int j = 0; j < YC; j++) begin
        a = '0;
        for (int k = 0; k < KC; k++) begin
          p = 64'(mx[i*KC+k]) * 64'(my[k*YC+j]);
`ifdef MM_SATURATE_EN
          if (p > 64'(MAXV)) p = 64'(MAXV);
          s = 64'(a) + p;
          a = (s > 64'(MAXV)) ? MAXV : s[DW-1:0];
`else
          s = 64'(a) + p;
          a = s[DW-1:0];
`endif
        end
        zq.push_back(a);
      end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
  endtask

  task automatic wr(input logic [1:0] s,
                    input logic [AW-1:0] a,
                    input logic [DW-1:0] v);
    @(negedge clk);
    ram_sel     = s;
    ram_addr    = a;
    ram_data_in = v;
    ram_wen     = 1'b1;
    @(negedge clk);
    ram_wen = 1'b0;
    if (s == 2'd0 && a < AW'(XR*KC)) mx[a] = v;
    if (s == 2'd1 && a < AW'(KC*YC)) my[a] = v;
  endtask

  task automatic rd(input logic [1:0] s,
                    input logic [AW-1:0] a,
                    output logic [DW-1:0] v);
    ram_sel  = s;
    ram_addr = a;
    #1 v = ram_data_out;
  endtask

  task automatic check_z(input string tag);
    logic [DW-1:0] v;
    for (int a = 0; a < XR*YC; a++) begin
      rd(2'd2, AW'(a), v);
      if (zq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s scoreboard empty got %h", tag, v);
      end else begin
        chk(tag, v, zq.pop_front());
      end
    end
  endtask

  task automatic load_basic();
    for (int n = 0; n < 4; n++) wr(2'd0, AW'(n), DW'(n + 1));
    for (int n = 0; n < 4; n++) wr(2'd1, AW'(n), DW'(n + 5));
  endtask

  task automatic run(input bit disturb,
                     input bit cowr,
                     input logic [AW-1:0] ca,
                     input logic [DW-1:0] cd);
    int cnt;
    @(negedge clk);
    start = 1'b1;
    if (cowr) begin
      ram_wen     = 1'b1;
      ram_sel     = 2'd0;
      ram_addr    = ca;
      ram_data_in = cd;
      mx[ca]      = cd;
    end
    push_expected();
    @(negedge clk);
    start   = 1'b0;
    ram_wen = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      if (disturb && cnt == 4) begin
        start       = 1'b1;
        ram_wen     = 1'b1;
        ram_sel     = 2'd0;
        ram_addr    = '0;
        ram_data_in = 32'd99;
      end else begin
        start   = 1'b0;
        ram_wen = 1'b0;
      end
      @(negedge clk);
    end
    chk("latency", DW'(cnt), DW'(LAT));
    check_z("z");
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    start = 1'b0;
    ram_addr = '0;
    ram_wen = 1'b0;
    ram_sel = '0;
    ram_data_in = '0;
    checks = 0;
    errors = 0;
    model_clear();
    do_reset();

    chk("rst_busy", DW'(busy), '0);
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 16; a++) begin
        rd(2'(s), AW'(a), d);
        chk("rst_rd", d, '0);
      end

    wr(2'd0, 4'd9, 32'd7);
    wr(2'd2, 4'd0, 32'd5);
    wr(2'd3, 4'd1, 32'd6);
    rd(2'd0, 4'd9, d);
    chk("oor_wr", d, '0);
    rd(2'd2, 4'd0, d);
    chk("z_wr", d, '0);
    rd(2'd3, 4'd1, d);
    chk("sel3_rd", d, '0);

    load_basic();
    run(1'b0, 1'b0, '0, '0);
    rd(2'd2, 4'd0, d);
    chk("basic_z0", d, 32'd19);
    rd(2'd2, 4'd3, d);
    chk("basic_z3", d, 32'd50);

    do_reset();
    wr(2'd0, 4'd0, 32'd1);
    wr(2'd0, 4'd0, 32'd1);
    wr(2'd0, 4'd1, 32'd2);
    wr(2'd0, 4'd1, 32'd2);
    wr(2'd1, 4'd0, 32'd1);
    wr(2'd1, 4'd0, 32'd1);
    wr(2'd1, 4'd1, 32'd2);
    wr(2'd1, 4'd1, 32'd2);
    run(1'b0, 1'b0, '0, '0);
    rd(2'd2, 4'd1, d);
    chk("rep_z1", d, 32'd2);

    do_reset();
    load_basic();
    run(1'b1, 1'b0, '0, '0);
    rd(2'd0, 4'd0, d);
    chk("busy_wr_x0", d, 32'd1);
    chk("idle_after", DW'(busy), '0);

    run(1'b0, 1'b1, 4'd3, 32'd10);
    rd(2'd0, 4'd3, d);
    chk("cowr_x3", d, 32'd10);

    do_reset();
    wr(2'd0, 4'd0, 32'hFFFF_FFFF);
    wr(2'd0, 4'd1, 32'hFFFF_FFFF);
    wr(2'd1, 4'd0, 32'd2);
    wr(2'd1, 4'd2, 32'd2);
    run(1'b0, 1'b0, '0, '0);
    rd(2'd2, 4'd0, d);
`ifdef MM_SATURATE_EN
    chk("sat_z0", d, 32'hFFFF_FFFF);
`else
    chk("wrap_z0", d, 32'hFFFF_FFFC);
`endif

    do_reset();
    load_basic();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy_pre", DW'(busy), 32'd1);
    #2 rst = 1'b0;
    #1 chk("abort_busy", DW'(busy), '0);
    for (int a = 0; a < XR*YC; a++) begin
      rd(2'd2, AW'(a), d);
      chk("abort_z", d, '0);
    end
    rd(2'd0, 4'd3, d);
    chk("abort_x3", d, '0);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    load_basic();
    run(1'b0, 1'b0, '0, '0);

    chk("sb_drained", DW'(zq.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
